// File: rtl/memoria_pkg.sv
// Shared definitions for the byte-addressable MEM-stage data memory:
// access size codes and the clear-sweep state encoding.
package memoria_pkg;

  // Access size codes carried on i_Tamanio; 2'b11 is reserved and
  // is treated as an access error.
  localparam logic [1:0] TAM_BYTE    = 2'b00;
  localparam logic [1:0] TAM_MEDIA   = 2'b01;
  localparam logic [1:0] TAM_PALABRA = 2'b10;

  // LIMPIAR: the memory is being swept to zero, requests are ignored.
  // LISTO:   normal load/store operation.
  typedef enum logic {
    LIMPIAR = 1'b0,
    LISTO   = 1'b1
  } estado_t;

endpackage

// File: rtl/memoria_datos_bytes_if.sv
// Access bus between the MEM stage and the data memory.
// Handshake: there is no valid/ready pair. A request is i_MemRead and/or
// i_MemWrite high at a rising edge while o_Ocupado is low; it is then
// accepted unconditionally and its result (o_DatoLeido, o_Excepcion)
// is valid after that same edge and held until the next accepted request.
// While o_Ocupado is high requests are silently dropped.
interface memoria_datos_bytes_if #(
  parameter int NBITS = 32
);

  logic [NBITS-1:0] i_ALUDireccion;
  logic [NBITS-1:0] i_DatoRegistro;
  logic             i_MemWrite;
  logic             i_MemRead;
  logic [1:0]       i_Tamanio;
  logic             i_SinSigno;
  logic [NBITS-1:0] o_DatoLeido;
  logic             o_Excepcion;
  logic             o_Ocupado;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output i_ALUDireccion, i_DatoRegistro, i_MemWrite, i_MemRead,
    output i_Tamanio, i_SinSigno,
    input  o_DatoLeido, o_Excepcion, o_Ocupado
  );

  // Memory side.
  modport slave (
    input  i_ALUDireccion, i_DatoRegistro, i_MemWrite, i_MemRead,
    input  i_Tamanio, i_SinSigno,
    output o_DatoLeido, o_Excepcion, o_Ocupado
  );

endinterface

// File: rtl/memoria_datos_bytes_alineador_carga.sv
// Lane steering for the data memory: picks the addressed byte/half out of
// a stored word and extends it, merges store data into the addressed lane
// of the old word, and flags misaligned or reserved-size accesses.
module alineador_carga
  import memoria_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] i_palabra,
  input  logic [1:0]       i_carril,
  input  logic [1:0]       i_tamanio,
  input  logic             i_sin_signo,
  input  logic [NBITS-1:0] i_dato_store,
  output logic [NBITS-1:0] o_carga,
  output logic [NBITS-1:0] o_mezcla,
  output logic             o_desalineado
);

  logic [4:0]  w_base_byte;
  logic [4:0]  w_base_media;
  logic [7:0]  w_byte;
  logic [15:0] w_media;

  // Bit offsets of the addressed byte and half within the word (little-endian).
  assign w_base_byte  = {i_carril, 3'b000};
  assign w_base_media = {i_carril[1], 4'b0000};
  assign w_byte       = i_palabra[w_base_byte +: 8];
  assign w_media      = i_palabra[w_base_media +: 16];

  // Size-dependent extension, read-modify-write merge and alignment check.
  always_comb begin
    o_carga       = '0;
    o_mezcla      = i_palabra;
    o_desalineado = 1'b0;
    case (i_tamanio)
      TAM_BYTE: begin
        o_carga = i_sin_signo ? {{(NBITS-8){1'b0}}, w_byte}
                              : {{(NBITS-8){w_byte[7]}}, w_byte};
        o_mezcla[w_base_byte +: 8] = i_dato_store[7:0];
      end
      TAM_MEDIA: begin
        o_desalineado = i_carril[0];
        o_carga = i_sin_signo ? {{(NBITS-16){1'b0}}, w_media}
                              : {{(NBITS-16){w_media[15]}}, w_media};
        o_mezcla[w_base_media +: 16] = i_dato_store[15:0];
      end
      TAM_PALABRA: begin
        o_desalineado = (i_carril != 2'b00);
        o_carga       = i_palabra;
        o_mezcla      = i_dato_store;
      end
      default: begin
        o_desalineado = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/memoria_datos_bytes.sv
// Byte-addressable data memory for the MEM stage. Holds the storage array,
// the post-reset clear sweep, error gating and the registered result and
// debug ports. All outputs come straight from registers.
module memoria_datos_bytes
  import memoria_pkg::*;
#(
  parameter  int NBITS  = 32,
  parameter  int CELDAS = 64,
  localparam int NIDX   = $clog2(CELDAS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  memoria_datos_bytes_if.slave  bus,
  input  logic [NIDX-1:0]       i_DebugDireccion,
  output logic [NBITS-1:0]      o_DebugDato,
  output estado_t               o_Estado
);

  logic [NBITS-1:0] r_mem [CELDAS];
  estado_t          r_estado;
  logic [NIDX-1:0]  r_cnt;
  logic [NBITS-1:0] r_DatoLeido;
  logic             r_Excepcion;
  logic             r_Ocupado;
  logic [NBITS-1:0] r_DebugDato;

  logic [NIDX-1:0]  w_idx;
  logic [1:0]       w_carril;
  logic             w_fuera;
  logic             w_desalineado;
  logic             w_err;
  logic             w_acceso;
  logic [NBITS-1:0] w_palabra;
  logic [NBITS-1:0] w_carga;
  logic [NBITS-1:0] w_mezcla;
  logic             w_we;
  logic [NIDX-1:0]  w_we_idx;
  logic [NBITS-1:0] w_we_dato;

  assign w_idx     = bus.i_ALUDireccion[NIDX+1:2];
  assign w_carril  = bus.i_ALUDireccion[1:0];
  assign w_fuera   = |bus.i_ALUDireccion[NBITS-1:NIDX+2];
  assign w_err     = w_fuera | w_desalineado;
  assign w_acceso  = bus.i_MemRead | bus.i_MemWrite;
  // Read-first: the load path always sees the word before this edge's write.
  assign w_palabra = r_mem[w_idx];

  alineador_carga #(
    .NBITS(NBITS)
  ) u_alineador (
    .i_palabra     (w_palabra),
    .i_carril      (w_carril),
    .i_tamanio     (bus.i_Tamanio),
    .i_sin_signo   (bus.i_SinSigno),
    .i_dato_store  (bus.i_DatoRegistro),
    .o_carga       (w_carga),
    .o_mezcla      (w_mezcla),
    .o_desalineado (w_desalineado)
  );

  // Single write port shared by the clear sweep and accepted, error-free stores.
  always_comb begin
    w_we      = 1'b0;
    w_we_idx  = r_cnt;
    w_we_dato = '0;
    if (!i_reset) begin
      if (r_estado == LIMPIAR) begin
        w_we = 1'b1;
      end else if (bus.i_MemWrite && !w_err) begin
        w_we      = 1'b1;
        w_we_idx  = w_idx;
        w_we_dato = w_mezcla;
      end
    end
  end

  // Storage array write.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_we_idx] <= w_we_dato;
    end
  end

  // Sweep FSM with registered load result, exception and busy flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_estado    <= LIMPIAR;
      r_cnt       <= '0;
      r_DatoLeido <= '0;
      r_Excepcion <= 1'b0;
      r_Ocupado   <= 1'b1;
    end else begin
      case (r_estado)
        LIMPIAR: begin
          if (r_cnt == NIDX'(CELDAS - 1)) begin
            r_estado  <= LISTO;
            r_cnt     <= '0;
            r_Ocupado <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LISTO: begin
          if (w_acceso) begin
            r_Excepcion <= w_err;
            r_DatoLeido <= w_err ? '0 : w_carga;
          end
        end
        default: begin
          r_estado  <= LIMPIAR;
          r_cnt     <= '0;
          r_Ocupado <= 1'b1;
        end
      endcase
    end
  end

  // Registered debug read; keeps sampling memory during the sweep.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_DebugDato <= '0;
    end else begin
      r_DebugDato <= r_mem[i_DebugDireccion];
    end
  end

  assign bus.o_DatoLeido = r_DatoLeido;
  assign bus.o_Excepcion = r_Excepcion;
  assign bus.o_Ocupado   = r_Ocupado;
  assign o_DebugDato     = r_DebugDato;
  assign o_Estado        = r_estado;

endmodule

// File: tb/tb_memoria_datos_bytes.sv
// Directed bench for memoria_datos_bytes (CELDAS=64). A driver issues
// requests and pushes the expected result; a monitor pops and compares
// one edge later.
module tb_memoria_datos_bytes;
  import memoria_pkg::*;

  localparam int NBITS  = 32;
  localparam int CELDAS = 64;
  localparam int NIDX   = $clog2(CELDAS);

  logic             clk;
  logic             rst;
  logic [NIDX-1:0]  dbg_dir;
  logic [NBITS-1:0] dbg_dato;
  estado_t          estado;

  memoria_datos_bytes_if #(.NBITS(NBITS)) bus_if ();

  memoria_datos_bytes #(
    .NBITS (NBITS),
    .CELDAS(CELDAS)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .bus             (bus_if),
    .i_DebugDireccion(dbg_dir),
    .o_DebugDato     (dbg_dato),
    .o_Estado        (estado)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  logic [NBITS-1:0] exp_q[$];
  logic             exp_exc_q[$];
  bit               exp_chk_q[$];
  string            exp_name_q[$];
  bit               pend = 1'b0;
  bit               pend_seen = 1'b0;

  always @(posedge clk) pend_seen <= pend;

  // Monitor: a request accepted at the last edge has its result on the bus now.
  always @(negedge clk) begin
    if (pend_seen) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_empty: result present, no expected entry");
      end else begin
        logic [NBITS-1:0] e_d;
        logic             e_x;
        bit               e_c;
        string            e_n;
        e_d = exp_q.pop_front();
        e_x = exp_exc_q.pop_front();
        e_c = exp_chk_q.pop_front();
        e_n = exp_name_q.pop_front();
        n_vec++;
        if (bus_if.o_Excepcion !== e_x) begin
          n_err++;
          $display("FAIL %s_exc: got %0b expected %0b", e_n, bus_if.o_Excepcion, e_x);
        end
        if (e_c) begin
          n_vec++;
          if (bus_if.o_DatoLeido !== e_d) begin
            n_err++;
            $display("FAIL %s_dato: got %08h expected %08h", e_n, bus_if.o_DatoLeido, e_d);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic idle_bus();
    bus_if.i_ALUDireccion = '0;
    bus_if.i_DatoRegistro = '0;
    bus_if.i_MemWrite     = 1'b0;
    bus_if.i_MemRead      = 1'b0;
    bus_if.i_Tamanio      = TAM_PALABRA;
    bus_if.i_SinSigno     = 1'b0;
  endtask

  task automatic acceso(input string name, input logic rd, input logic wr,
                        input logic [1:0] tam, input logic sin_signo,
                        input logic [NBITS-1:0] dir, input logic [NBITS-1:0] dato,
                        input bit chk, input logic [NBITS-1:0] e_dato, input logic e_exc);
    bus_if.i_ALUDireccion = dir;
    bus_if.i_DatoRegistro = dato;
    bus_if.i_MemRead      = rd;
    bus_if.i_MemWrite     = wr;
    bus_if.i_Tamanio      = tam;
    bus_if.i_SinSigno     = sin_signo;
    exp_q.push_back(e_dato);
    exp_exc_q.push_back(e_exc);
    exp_chk_q.push_back(chk);
    exp_name_q.push_back(name);
    pend = 1'b1;
    @(negedge clk);
    pend = 1'b0;
    idle_bus();
  endtask

  task automatic load(input string name, input logic [1:0] tam, input logic sin_signo,
                      input logic [NBITS-1:0] dir, input logic [NBITS-1:0] e_dato,
                      input logic e_exc);
    acceso(name, 1'b1, 1'b0, tam, sin_signo, dir, '0, 1'b1, e_dato, e_exc);
  endtask

  task automatic store(input string name, input logic [1:0] tam,
                       input logic [NBITS-1:0] dir, input logic [NBITS-1:0] dato,
                       input logic e_exc);
    // An erroring store must also force the load result to zero.
    acceso(name, 1'b0, 1'b1, tam, 1'b0, dir, dato, e_exc, '0, e_exc);
  endtask

  task automatic check(input string name, input logic [NBITS-1:0] got,
                       input logic [NBITS-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic chk_debug(input string name, input int idx, input logic [NBITS-1:0] exp);
    dbg_dir = NIDX'(idx);
    @(negedge clk);
    check(name, dbg_dato, exp);
  endtask

  // Releases reset at the current negedge and counts cycles of o_Ocupado high.
  // Optionally fires an ignored store+load and an ignored error load mid-sweep.
  task automatic contar_barrido(input string name, input bit intruso);
    int n;
    n = 0;
    rst = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (intruso && n == 50) begin
        bus_if.i_ALUDireccion = 32'h0;
        bus_if.i_DatoRegistro = 32'hFFFF_FFFF;
        bus_if.i_MemWrite     = 1'b1;
        bus_if.i_MemRead      = 1'b1;
        bus_if.i_Tamanio      = TAM_PALABRA;
      end else if (intruso && n == 51) begin
        bus_if.i_ALUDireccion = 32'h3;
        bus_if.i_MemWrite     = 1'b0;
        bus_if.i_MemRead      = 1'b1;
        bus_if.i_Tamanio      = TAM_MEDIA;
      end else if (intruso && n == 52) begin
        idle_bus();
      end
      if (!bus_if.o_Ocupado) break;
    end
    check({name, "_ciclos_ocupado"}, n, 64);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    dbg_dir = '0;
    idle_bus();
    @(negedge clk);
    @(negedge clk);

    // Reset values.
    check("reset_dato", bus_if.o_DatoLeido, 32'h0);
    check("reset_debug", dbg_dato, 32'h0);
    check("reset_exc", {31'b0, bus_if.o_Excepcion}, 32'h0);
    check("reset_ocupado", {31'b0, bus_if.o_Ocupado}, 32'h1);

    contar_barrido("barrido", 1'b0);

    // First request right after o_Ocupado falls.
    load("ld_w_10", TAM_PALABRA, 1'b0, 32'h10, 32'h0000_0000, 1'b0);

    // Word store, then lane loads.
    store("st_w_8", TAM_PALABRA, 32'h8, 32'hDEAD_BEEF, 1'b0);
    load("ld_b_9_s", TAM_BYTE, 1'b0, 32'h9, 32'hFFFF_FFBE, 1'b0);
    load("ld_b_9_u", TAM_BYTE, 1'b1, 32'h9, 32'h0000_00BE, 1'b0);
    load("ld_h_a_s", TAM_MEDIA, 1'b0, 32'hA, 32'hFFFF_DEAD, 1'b0);
    load("ld_h_a_u", TAM_MEDIA, 1'b1, 32'hA, 32'h0000_DEAD, 1'b0);
    load("ld_b_8_s", TAM_BYTE, 1'b0, 32'h8, 32'hFFFF_FFEF, 1'b0);
    load("ld_h_8_s", TAM_MEDIA, 1'b0, 32'h8, 32'hFFFF_BEEF, 1'b0);
    load("ld_w_8_u", TAM_PALABRA, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0);
    chk_debug("debug_w2", 2, 32'hDEAD_BEEF);

    // Byte and half merges leave other lanes intact.
    store("st_b_b", TAM_BYTE, 32'hB, 32'hFFFF_FF11, 1'b0);
    load("ld_w_8_tras_b", TAM_PALABRA, 1'b0, 32'h8, 32'h11AD_BEEF, 1'b0);
    store("st_h_8", TAM_MEDIA, 32'h8, 32'hABCD_1234, 1'b0);
    load("ld_w_8_tras_h", TAM_PALABRA, 1'b0, 32'h8, 32'h11AD_1234, 1'b0);

    // Error cases.
    store("st_w_4", TAM_PALABRA, 32'h4, 32'h5566_7788, 1'b0);
    store("st_w_6_desal", TAM_PALABRA, 32'h6, 32'h0000_0000, 1'b1);
    load("ld_w_4_intacta", TAM_PALABRA, 1'b0, 32'h4, 32'h5566_7788, 1'b0);
    load("ld_h_6_u", TAM_MEDIA, 1'b1, 32'h6, 32'h0000_5566, 1'b0);
    load("ld_h_3_desal", TAM_MEDIA, 1'b0, 32'h3, 32'h0, 1'b1);
    store("st_w_100_rango", TAM_PALABRA, 32'h100, 32'hFFFF_FFFF, 1'b1);
    load("ld_w_0_intacta", TAM_PALABRA, 1'b0, 32'h0, 32'h0, 1'b0);
    load("ld_tam_reservado", 2'b11, 1'b0, 32'h8, 32'h0, 1'b1);
    load("ld_b_rango_alto", TAM_BYTE, 1'b1, 32'h8000_0009, 32'h0, 1'b1);

    // Same-cycle read and write returns the old contents.
    store("st_w_8_unos", TAM_PALABRA, 32'h8, 32'h1111_1111, 1'b0);
    acceso("rw_w_8", 1'b1, 1'b1, TAM_PALABRA, 1'b0, 32'h8, 32'hCAFE_F00D,
           1'b1, 32'h1111_1111, 1'b0);
    load("ld_w_8_nuevo", TAM_PALABRA, 1'b0, 32'h8, 32'hCAFE_F00D, 1'b0);
    // Outputs hold while the bus is idle.
    @(negedge clk);
    check("hold_dato", bus_if.o_DatoLeido, 32'hCAFE_F00D);

    // Last cell and its lanes.
    store("st_w_fc", TAM_PALABRA, 32'hFC, 32'hA5A5_A5A5, 1'b0);
    load("ld_b_ff_s", TAM_BYTE, 1'b0, 32'hFF, 32'hFFFF_FFA5, 1'b0);
    load("ld_h_fe_u", TAM_MEDIA, 1'b1, 32'hFE, 32'h0000_A5A5, 1'b0);
    chk_debug("debug_w63", 63, 32'hA5A5_A5A5);

    // Reset mid-sweep: restart, count a full 64 more cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("estado_barriendo", {31'b0, estado}, {31'b0, LIMPIAR});
    rst = 1'b1;
    @(negedge clk);
    contar_barrido("rebarrido", 1'b1);
    check("intruso_dato", bus_if.o_DatoLeido, 32'h0);
    check("intruso_exc", {31'b0, bus_if.o_Excepcion}, 32'h0);
    for (int i = 0; i < CELDAS; i++) begin
      chk_debug($sformatf("limpia_%0d", i), i, 32'h0);
    end
    load("ld_w_8_limpia", TAM_PALABRA, 1'b0, 32'h8, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/memoria_datos_bytes.md
# memoria_datos_bytes

Parametrised data memory for the MIPS pipeline MEM stage. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. It also flags misaligned and out-of-range accesses, and clears itself through a reset-triggered sweep FSM. A registered debug read port serves the debug unit; all writes occur on the rising edge.

## Interface
- NBITS, 32, data and address width (fixed at 32 for the pipeline)
- CELDAS, 64, number of NBITS-wide words; must be a power of two, 2 to 1024
- NIDX, $clog2(CELDAS), word-index width (derived, not overridden)
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_ALUDireccion  in  NBITS  byte address from the ALU
- i_DatoRegistro  in  NBITS  store data, right-aligned (byte in [7:0], half in [15:0])
- i_MemWrite  in  1  store request
- i_MemRead  in  1  load request
- i_Tamanio  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- i_SinSigno  in  1  load zero-extends when 1, sign-extends when 0
- i_DebugDireccion  in  NIDX  word index for debug read
- o_DatoLeido  out  NBITS  load result, right-aligned and extended
- o_DebugDato  out  NBITS  memory[i_DebugDireccion], registered
- o_Excepcion  out  1  last accepted access was misaligned, out of range or reserved size
- o_Ocupado  out  1  clear sweep in progress; requests ignored

## Operation
- Byte order is little-endian. Word index = i_ALUDireccion[NIDX+1:2]; byte lane = i_ALUDireccion[1:0].
- Out of range: any of i_ALUDireccion[NBITS-1:NIDX+2] nonzero.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. i_Tamanio=11 also counts as an error.
- Any error suppresses the write and forces o_DatoLeido=0. o_Excepcion is then 1.
- Store: byte-lane read-modify-write. Only the addressed byte or half changes; other lanes keep their values.
- Load: select the lane and extend it to NBITS using i_SinSigno. Word loads ignore i_SinSigno.
- Read and write in the same cycle to the same word: the write happens, and o_DatoLeido returns the pre-write contents (read-first).
- o_DatoLeido and o_Excepcion update only when i_MemRead or i_MemWrite is high; otherwise they hold their values.
- FSM states:
  - LIMPIAR: cnt writes 0 to memory[cnt] each cycle and increments. At cnt==CELDAS-1 it writes the last cell and moves to LISTO.
  - LISTO: normal operation.
- i_reset in any state: state←LIMPIAR, cnt←0. This also applies mid-sweep, where the sweep restarts from 0.
- During LIMPIAR, i_MemRead and i_MemWrite are ignored. o_DebugDato still samples memory.

## Timing
- Reset values after the reset edge: o_DatoLeido=0, o_DebugDato=0, o_Excepcion=0, o_Ocupado=1, cnt=0.
- Sweep:
  - With reset deasserted after edge k, edges k+1..k+CELDAS clear cells 0..CELDAS-1.
  - o_Ocupado is low after edge k+CELDAS.
  - A first request presented in cycle k+CELDAS+1 is accepted.
- Load latency is 1 cycle: request at edge n produces o_DatoLeido valid after edge n.
- Store is visible to a load issued on the following edge.
- o_Excepcion is valid together with o_DatoLeido for the same request.
- Debug latency is 1 cycle. During LIMPIAR, o_DebugDato reflects partially cleared memory.
- No combinational path from inputs to outputs.

## Structure
- Shared package memoria_pkg holds:
  - size codes TAM_BYTE=2'b00, TAM_MEDIA=2'b01, TAM_PALABRA=2'b10;
  - state encoding LIMPIAR/LISTO.
- Sub-module alineador_carga: combinational block for lane select, extension and store merge.
  - Inputs: word, lane, size, unsigned, store data.
  - Outputs: extended load value, merged store word, misaligned flag.
- The top level holds the memory array, FSM and counter, error gating and output registers.

## Test plan
- Reset, then idle (CELDAS=64): o_Ocupado stays high for exactly 64 cycles. A word load at 0x10 then returns 0x00000000 with o_Excepcion=0.
- Store word 0xDEADBEEF at 0x8, then loads:
  - byte 0x9 signed → 0xFFFFFFBE;
  - byte 0x9 unsigned → 0x000000BE;
  - half 0xA signed → 0xFFFFDEAD;
  - half 0xA unsigned → 0x0000DEAD.
- Store byte 0x11 at 0xB, then word load 0x8 → 0x11ADBEEF. Store half 0x1234 at 0x8, then word load 0x8 → 0x11AD1234.
- Errors:
  - Word store at 0x6 → o_Excepcion=1, word 1 unchanged.
  - Half load at 0x3 → o_DatoLeido=0, o_Excepcion=1.
  - Word store at 0x100 → o_Excepcion=1, no cell modified.
- Same-cycle read and write: word store 0xCAFEF00D with word load at 0x8 (holding 0x11111111) → o_DatoLeido=0x11111111. The next load returns 0xCAFEF00D.
- Reset mid-sweep: assert i_reset at cnt=20 → o_Ocupado stays high for a further 64 cycles. A request issued during the sweep has no effect, and every cell reads 0 afterwards.
